// File: rtl/gnt_xfer_pkg.sv
// Shared types and helpers for the grant-driven transfer mux.
package gnt_xfer_pkg;

  localparam int NUM_SRC = 3;

  typedef logic [1:0] src_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // True when more than one grant bit is set.
  function automatic logic onehot_multi(input logic [NUM_SRC-1:0] gnt);
    logic [NUM_SRC-1:0] w_dec;
    w_dec = gnt - {{(NUM_SRC-1){1'b0}}, 1'b1};
    return (gnt & w_dec) != '0;
  endfunction

endpackage

// File: rtl/gnt_xfer_mux_enc.sv
// One-hot grant to index encoder; the lowest set bit wins when the grant is multi-hot.
module gnt_onehot_enc
  import gnt_xfer_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_gnt,
  output src_idx_t           o_idx,
  output logic               o_any,
  output logic               o_multi
);

  always_comb begin
    o_idx = src_idx_t'(0);
    if (i_gnt[0])      o_idx = src_idx_t'(0);
    else if (i_gnt[1]) o_idx = src_idx_t'(1);
    else if (i_gnt[2]) o_idx = src_idx_t'(2);
  end

  assign o_any   = |i_gnt;
  assign o_multi = onehot_multi(i_gnt);

endmodule

// File: rtl/gnt_xfer_mux.sv
// Moves beats from the granted source to one registered valid/ready stream, locking for a burst.
// Optional per-source accepted-beat counters are built when GNT_XFER_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | follow gnt; first beat of a burst (or a single-beat burst)
//   BURST | serve the locked owner only; arb_hold asserted
module gnt_xfer_mux
  import gnt_xfer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_SRC-1:0]              i_gnt,
  input  logic [NUM_SRC-1:0]              i_src_valid,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  i_src_data,
  input  logic [NUM_SRC-1:0]              i_src_last,
  output logic [NUM_SRC-1:0]              o_src_ack,
  output logic                            o_out_valid,
  output logic [DATA_W-1:0]               o_out_data,
  output logic [1:0]                      o_out_src,
  output logic                            o_out_last,
  input  logic                            i_out_ready,
  output logic                            o_arb_hold,
  output logic                            o_gnt_err,
  output logic                            o_trunc_err
`ifdef GNT_XFER_STATS_EN
  ,
  output logic [15:0]                     o_beat_cnt0,
  output logic [15:0]                     o_beat_cnt1,
  output logic [15:0]                     o_beat_cnt2
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_BURST);

  state_e              r_state;
  src_idx_t            r_owner;
  cnt_t                r_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  src_idx_t            r_out_src;
  logic                r_out_last;
  logic                r_arb_hold;
  logic                r_gnt_err;
  logic                r_trunc_err;

  src_idx_t            w_sel;
  logic                w_gnt_any;
  logic                w_gnt_multi;
  logic                w_slot_free;
  state_e              w_state_nxt;
  src_idx_t            w_owner_nxt;
  cnt_t                w_cnt_nxt;
  cnt_t                w_cnt_inc;
  logic                w_load;
  src_idx_t            w_load_src;
  logic                w_load_last;
  logic                w_trunc;
  logic                w_gnt_err_set;
  logic [NUM_SRC-1:0]  w_ack;

  gnt_onehot_enc u_enc (
    .i_gnt   (i_gnt),
    .o_idx   (w_sel),
    .o_any   (w_gnt_any),
    .o_multi (w_gnt_multi)
  );

  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_cnt_inc   = r_cnt + cnt_t'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_load        = 1'b0;
    w_load_src    = r_owner;
    w_load_last   = 1'b0;
    w_trunc       = 1'b0;
    w_gnt_err_set = 1'b0;
    w_ack         = '0;

    case (r_state)
      IDLE: begin
        w_gnt_err_set = w_gnt_multi;
        if (w_gnt_any && i_src_valid[w_sel] && w_slot_free) begin
          w_load      = 1'b1;
          w_load_src  = w_sel;
          w_load_last = i_src_last[w_sel];
          w_owner_nxt = w_sel;
          w_cnt_nxt   = cnt_t'(1);
          if (!i_src_last[w_sel]) w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (i_src_valid[r_owner] && w_slot_free) begin
          w_load     = 1'b1;
          w_load_src = r_owner;
          w_cnt_nxt  = w_cnt_inc;
          if (i_src_last[r_owner]) begin
            w_load_last = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_cnt_inc == CNT_MAX) begin
            // Cut the burst here; the owner must win arbitration again to continue.
            w_load_last = 1'b1;
            w_trunc     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) w_ack[w_load_src] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_owner     <= src_idx_t'(0);
      r_cnt       <= '0;
      r_arb_hold  <= 1'b0;
      r_gnt_err   <= 1'b0;
      r_trunc_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_arb_hold  <= (w_state_nxt == BURST);
      r_gnt_err   <= r_gnt_err | w_gnt_err_set;
      r_trunc_err <= r_trunc_err | w_trunc;
    end
  end

  // Load and drain may coincide, giving one beat per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= src_idx_t'(0);
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_src_data[w_load_src];
      r_out_src   <= w_load_src;
      r_out_last  <= w_load_last;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef GNT_XFER_STATS_EN
  logic [15:0] r_beat_cnt [NUM_SRC];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SRC; i++) r_beat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_out_valid && i_out_ready && (r_out_src == src_idx_t'(i)) &&
            (r_beat_cnt[i] != 16'hFFFF))
          r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
      end
    end
  end

  assign o_beat_cnt0 = r_beat_cnt[0];
  assign o_beat_cnt1 = r_beat_cnt[1];
  assign o_beat_cnt2 = r_beat_cnt[2];
`endif

  // The ack is combinational, so it is gated by reset to keep it quiet while rst is held.
  assign o_src_ack   = i_rst ? '0 : w_ack;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;
  assign o_out_last  = r_out_last;
  assign o_arb_hold  = r_arb_hold;
  assign o_gnt_err   = r_gnt_err;
  assign o_trunc_err = r_trunc_err;

endmodule

// File: tb/tb_gnt_xfer_mux.sv
// Scoreboard bench for gnt_xfer_mux: sources are modelled as beat queues, expected output beats are queued as stimulus is set up.
module tb_gnt_xfer_mux;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        gnt = 3'b000;
  logic [2:0]        src_valid = 3'b000;
  logic [2:0][31:0]  src_data = '0;
  logic [2:0]        src_last = 3'b000;
  logic [2:0]        src_ack;
  logic              out_valid;
  logic [31:0]       out_data;
  logic [1:0]        out_src;
  logic              out_last;
  logic              out_ready = 1'b1;
  logic              arb_hold;
  logic              gnt_err;
  logic              trunc_err;
`ifdef GNT_XFER_STATS_EN
  logic [15:0]       beat_cnt0, beat_cnt1, beat_cnt2;
`endif

  beat_t       sq [3][$];
  beat_t       exp_q [$];
  logic [2:0]  ack_n = 3'b000;
  int          checks = 0;
  int          failures = 0;

  gnt_xfer_mux #(.DATA_W(32), .MAX_BURST(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_gnt       (gnt),
    .i_src_valid (src_valid),
    .i_src_data  (src_data),
    .i_src_last  (src_last),
    .o_src_ack   (src_ack),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_src   (out_src),
    .o_out_last  (out_last),
    .i_out_ready (out_ready),
    .o_arb_hold  (arb_hold),
    .o_gnt_err   (gnt_err),
    .o_trunc_err (trunc_err)
`ifdef GNT_XFER_STATS_EN
    ,
    .o_beat_cnt0 (beat_cnt0),
    .o_beat_cnt1 (beat_cnt1),
    .o_beat_cnt2 (beat_cnt2)
`endif
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the ack seen mid-cycle is the one committed at the next edge.
  always @(negedge clk) ack_n = src_ack;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (ack_n[i] && !rst && sq[i].size() > 0) void'(sq[i].pop_front());
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sq[i].size() > 0) begin
        src_valid[i] = 1'b1;
        src_data[i]  = sq[i][0].data;
        src_last[i]  = sq[i][0].last;
      end else begin
        src_valid[i] = 1'b0;
        src_data[i]  = '0;
        src_last[i]  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_beat unexpected: data=%h src=%0d last=%b", out_data, out_src, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_src !== e.src || out_last !== e.last) begin
          failures++;
          $display("FAIL out_beat got data=%h src=%0d last=%b exp data=%h src=%0d last=%b",
                   out_data, out_src, out_last, e.data, e.src, e.last);
        end
      end
    end
  end

  task automatic src_push(input int s, input logic [31:0] d, input logic l);
    sq[s].push_back('{data: d, src: 2'(s), last: l});
  endtask

  task automatic exp_push(input int s, input logic [31:0] d, input logic l);
    exp_q.push_back('{data: d, src: 2'(s), last: l});
  endtask

  task automatic wait_empty(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    src_push(0, 32'hDEAD_0001, 1'b1);
    gnt = 3'b001;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (out_src !== 2'd0) begin failures++; $display("FAIL rst_out_src got=%0d exp=0", out_src); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (arb_hold !== 1'b0) begin failures++; $display("FAIL rst_arb_hold got=%b exp=0", arb_hold); end
    checks++; if (gnt_err !== 1'b0 || trunc_err !== 1'b0) begin failures++; $display("FAIL rst_errs got=%b%b exp=00", gnt_err, trunc_err); end
    checks++; if (src_ack !== 3'b000) begin failures++; $display("FAIL rst_src_ack got=%b exp=000", src_ack); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_push(0, 32'hDEAD_0001, 1'b1);
    @(negedge clk);
    checks++; if (src_ack !== 3'b001) begin failures++; $display("FAIL post_rst_ack got=%b exp=001", src_ack); end
    wait_empty(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_rst_drain timeout left=%0d", exp_q.size()); end
    gnt = 3'b000;
  endtask

  task automatic test_single();
    src_push(1, 32'h0000_00A5, 1'b1);
    exp_push(1, 32'h0000_00A5, 1'b1);
    @(posedge clk); #1;
    gnt = 3'b010;
    @(negedge clk);
    checks++; if (src_ack !== 3'b010) begin failures++; $display("FAIL single_ack got=%b exp=010", src_ack); end
    @(posedge clk); #1;
    gnt = 3'b000;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_src !== 2'd1 || out_last !== 1'b1) begin
      failures++; $display("FAIL single_out got v=%b d=%h s=%0d l=%b exp v=1 d=a5 s=1 l=1", out_valid, out_data, out_src, out_last);
    end
    checks++; if (arb_hold !== 1'b0) begin failures++; $display("FAIL single_hold got=%b exp=0", arb_hold); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int  hold_cnt;
    bit  seen0;
    for (int i = 0; i < 4; i++) begin
      src_push(2, 32'h0000_0020 + 32'(i), (i == 3));
      exp_push(2, 32'h0000_0020 + 32'(i), (i == 3));
    end
    src_push(0, 32'h0000_000C, 1'b1);
    exp_push(0, 32'h0000_000C, 1'b1);
    hold_cnt = 0;
    seen0 = 1'b0;
    @(posedge clk); #1;
    gnt = 3'b100;
    @(negedge clk);
    checks++; if (src_ack !== 3'b100) begin failures++; $display("FAIL burst_first_ack got=%b exp=100", src_ack); end
    @(posedge clk); #1;
    gnt = 3'b001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (arb_hold) hold_cnt++;
      if (src_ack[0]) begin
        seen0 = 1'b1;
        checks++;
        if (arb_hold !== 1'b0 || sq[2].size() != 0) begin
          failures++; $display("FAIL burst_src0_early got hold=%b src2_left=%0d exp hold=0 src2_left=0", arb_hold, sq[2].size());
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (hold_cnt != 3) begin failures++; $display("FAIL burst_hold_cycles got=%0d exp=3", hold_cnt); end
    checks++; if (!seen0 || exp_q.size() != 0) begin failures++; $display("FAIL burst_src0_served got seen=%b left=%0d exp seen=1 left=0", seen0, exp_q.size()); end
    gnt = 3'b000;
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      src_push(1, 32'h0000_0040 + 32'(i), (i == 3));
      exp_push(1, 32'h0000_0040 + 32'(i), (i == 3));
    end
    @(posedge clk); #1;
    gnt = 3'b010;
    @(negedge clk);
    checks++; if (src_ack !== 3'b010) begin failures++; $display("FAIL bp_first_ack got=%b exp=010", src_ack); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    gnt = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (src_ack !== 3'b000 || out_valid !== 1'b1 || out_data !== 32'h40) begin
        failures++; $display("FAIL bp_stall cyc=%0d got ack=%b v=%b d=%h exp ack=000 v=1 d=40", c, src_ack, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (src_ack !== 3'b010 || out_data !== 32'h40) begin
      failures++; $display("FAIL bp_release got ack=%b d=%h exp ack=010 d=40", src_ack, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_data !== 32'h41) begin failures++; $display("FAIL bp_next_beat got=%h exp=41", out_data); end
    wait_empty(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain timeout left=%0d", exp_q.size()); end
  endtask

  task automatic test_trunc();
    bit ok;
    for (int i = 0; i < 10; i++) src_push(0, 32'h0000_0080 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) exp_push(0, 32'h0000_0080 + 32'(i), (i == 7));
    @(posedge clk); #1;
    gnt = 3'b001;
    @(negedge clk);
    checks++; if (src_ack !== 3'b001) begin failures++; $display("FAIL trunc_first_ack got=%b exp=001", src_ack); end
    @(posedge clk); #1;
    gnt = 3'b000;
    wait_empty(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_drain timeout left=%0d", exp_q.size()); end
    checks++; if (trunc_err !== 1'b1) begin failures++; $display("FAIL trunc_err got=%b exp=1", trunc_err); end
    checks++; if (arb_hold !== 1'b0) begin failures++; $display("FAIL trunc_idle_hold got=%b exp=0", arb_hold); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (src_ack !== 3'b000) begin failures++; $display("FAIL trunc_wait_grant got ack=%b exp=000", src_ack); end
      @(posedge clk); #1;
    end
    checks++; if (sq[0].size() != 2) begin failures++; $display("FAIL trunc_remaining got=%0d exp=2", sq[0].size()); end
    src_push(0, 32'h0000_008A, 1'b1);
    exp_push(0, 32'h0000_0088, 1'b0);
    exp_push(0, 32'h0000_0089, 1'b0);
    exp_push(0, 32'h0000_008A, 1'b1);
    @(posedge clk); #1;
    gnt = 3'b001;
    wait_empty(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_regrant timeout left=%0d", exp_q.size()); end
    gnt = 3'b000;
  endtask

  task automatic test_multihot();
    bit ok;
    checks++; if (gnt_err !== 1'b0) begin failures++; $display("FAIL mh_pre_err got=%b exp=0", gnt_err); end
    src_push(1, 32'h0000_0011, 1'b1);
    src_push(2, 32'h0000_0022, 1'b1);
    exp_push(1, 32'h0000_0011, 1'b1);
    exp_push(2, 32'h0000_0022, 1'b1);
    @(posedge clk); #1;
    gnt = 3'b110;
    @(negedge clk);
    checks++; if (src_ack !== 3'b010) begin failures++; $display("FAIL mh_ack got=%b exp=010", src_ack); end
    @(posedge clk); #1;
    gnt = 3'b000;
    @(negedge clk);
    checks++; if (gnt_err !== 1'b1 || out_src !== 2'd1) begin
      failures++; $display("FAIL mh_err got err=%b src=%0d exp err=1 src=1", gnt_err, out_src);
    end
    @(posedge clk); #1;
    gnt = 3'b100;
    @(negedge clk);
    checks++; if (src_ack !== 3'b100) begin failures++; $display("FAIL mh_src2_ack got=%b exp=100", src_ack); end
    wait_empty(20, ok);
    checks++; if (!ok || gnt_err !== 1'b1) begin failures++; $display("FAIL mh_sticky got ok=%b err=%b exp ok=1 err=1", ok, gnt_err); end
    gnt = 3'b000;
  endtask

  task automatic test_reset_burst();
    bit ok;
    for (int i = 0; i < 5; i++) src_push(1, 32'h0000_0050 + 32'(i), (i == 4));
    exp_push(1, 32'h0000_0050, 1'b0);
    exp_push(1, 32'h0000_0051, 1'b0);
    @(posedge clk); #1;
    gnt = 3'b010;
    @(negedge clk);
    @(posedge clk); #1;
    gnt = 3'b000;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || arb_hold !== 1'b0) begin
      failures++; $display("FAIL rstb_immediate got v=%b hold=%b exp v=0 hold=0", out_valid, arb_hold);
    end
    checks++; if (src_ack !== 3'b000) begin failures++; $display("FAIL rstb_ack got=%b exp=000", src_ack); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rstb_beats_before got_left=%0d exp=0", exp_q.size()); end
    sq[1].delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    src_push(1, 32'h0000_005A, 1'b1);
    exp_push(1, 32'h0000_005A, 1'b1);
    @(posedge clk); #1;
    gnt = 3'b010;
    @(negedge clk);
    checks++; if (src_ack !== 3'b010) begin failures++; $display("FAIL rstb_new_ack got=%b exp=010", src_ack); end
    wait_empty(20, ok);
    checks++; if (!ok || arb_hold !== 1'b0) begin failures++; $display("FAIL rstb_new_beat got ok=%b hold=%b exp ok=1 hold=0", ok, arb_hold); end
    gnt = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_trunc();
    test_multihot();
    test_reset_burst();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
